// File: rtl/step_pulse_capture_if.sv
`default_nettype none
//==============================================================================
// Module      : step_pulse_capture_if
// Description : Pin, control and measurement bundle of step_pulse_capture.
//               The optional min/max outputs exist with STEP_PULSE_CAPTURE_MINMAX_EN.
// Revision    : 1.0 - initial release
//==============================================================================
interface step_pulse_capture_if;
    logic        pluse_in;
    logic        dir_in;
    logic        pluse_idle_level;
    logic        capture_en;
    logic        cnt_clear;
    logic [31:0] timeout_period;
    logic [31:0] pulse_count;
    logic [31:0] period_out;
    logic [31:0] high_width_out;
    logic        period_valid;
    logic        width_valid;
    logic        timeout_flag;
    logic        busy_state;
`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
    logic [31:0] period_min;
    logic [31:0] period_max;
`endif

    modport slave (
        input  pluse_in, dir_in, pluse_idle_level, capture_en, cnt_clear, timeout_period,
        output pulse_count, period_out, high_width_out, period_valid, width_valid,
               timeout_flag, busy_state
`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
        , output period_min, period_max
`endif
    );

    modport master (
        output pluse_in, dir_in, pluse_idle_level, capture_en, cnt_clear, timeout_period,
        input  pulse_count, period_out, high_width_out, period_valid, width_valid,
               timeout_flag, busy_state
`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
        , input period_min, period_max
`endif
    );
endinterface
`default_nettype wire

// File: rtl/step_pulse_capture.sv
`default_nettype none
//==============================================================================
// Module      : step_pulse_capture
// Description : Step/dir capture: sync, glitch filter, signed step count, period
//               and width measurement, pulse-loss timeout. Optional period min/max
//               tracking is enabled by STEP_PULSE_CAPTURE_MINMAX_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module step_pulse_capture #(
    parameter int SYNC_STAGES        = 2,
    parameter int GLITCH_FILTER_CLKS = 4
) (
    input  wire                 sys_clk,
    input  wire                 sys_rst_n,
    step_pulse_capture_if.slave bus
);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ACTIVE    = 2'd1;
    localparam logic [1:0] c_INACTIVE  = 2'd2;
    localparam logic [7:0] c_FILT_LAST = 8'(GLITCH_FILTER_CLKS - 1);

    logic [SYNC_STAGES-1:0] r_psync;
    logic [SYNC_STAGES-1:0] r_dsync;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [7:0]             r_fcnt;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [31:0]            r_elapsed;
    logic [31:0]            r_count;
    logic [31:0]            r_period;
    logic [31:0]            r_width;
    logic                   r_pv;
    logic                   r_wv;
    logic                   r_flag;
    logic                   w_en;
    logic                   w_idle;
    logic                   w_samp;
    logic                   w_dir;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_timeout;
    logic                   w_period_stb;
    logic                   w_width_stb;
    logic                   w_restart;

    assign w_en   = bus.capture_en;
    assign w_idle = bus.pluse_idle_level;
    assign w_samp = r_psync[SYNC_STAGES-1];
    assign w_dir  = r_dsync[SYNC_STAGES-1];

    // While disabled the pulse chain is parked at idle so re-enabling cannot fake an edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_psync <= '0;
            r_dsync <= '0;
        end else begin
            r_psync <= w_en ? {r_psync[SYNC_STAGES-2:0], bus.pluse_in} : {SYNC_STAGES{w_idle}};
            r_dsync <= {r_dsync[SYNC_STAGES-2:0], bus.dir_in};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_fcnt   <= '0;
        end else if (!w_en) begin
            r_filt   <= w_idle;
            r_filt_d <= w_idle;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (w_samp != r_filt) begin
                if (r_fcnt == c_FILT_LAST) begin
                    r_filt <= w_samp;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 8'd1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_rise    = w_en && (r_filt != w_idle) && (r_filt_d == w_idle);
    assign w_fall    = w_en && (r_filt == w_idle) && (r_filt_d != w_idle);
    assign w_timeout = w_en && (r_state != c_IDLE) && (bus.timeout_period != 32'd0) &&
                       (r_elapsed == bus.timeout_period);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= c_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_en || w_timeout) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:     if (w_rise) w_state_nxt = c_ACTIVE;
                c_ACTIVE:   if (w_fall) w_state_nxt = c_INACTIVE;
                c_INACTIVE: if (w_rise) w_state_nxt = c_ACTIVE;
                default:    w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Timeout outranks a coincident edge: the partial measurement is dropped
    always_comb begin
        w_period_stb = 1'b0;
        w_width_stb  = 1'b0;
        w_restart    = 1'b0;
        if (w_en && !w_timeout) begin
            w_period_stb = (r_state == c_INACTIVE) && w_rise;
            w_width_stb  = (r_state == c_ACTIVE) && w_fall;
            w_restart    = (r_state != c_ACTIVE) && w_rise;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                   r_elapsed <= '0;
        else if (w_state_nxt == c_IDLE)   r_elapsed <= '0;
        else if (w_restart)               r_elapsed <= 32'd1;
        else if (r_elapsed != 32'hFFFF_FFFF) r_elapsed <= r_elapsed + 32'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pv     <= 1'b0;
            r_wv     <= 1'b0;
            r_period <= '0;
            r_width  <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_pv <= w_period_stb;
            r_wv <= w_width_stb;
            if (w_period_stb) r_period <= r_elapsed;
            if (w_width_stb)  r_width  <= r_elapsed;
            if (bus.cnt_clear)   r_count <= '0;
            else if (w_rise)     r_count <= w_dir ? r_count + 32'd1 : r_count - 32'd1;
            if (w_timeout)                      r_flag <= 1'b1;
            else if (bus.cnt_clear || w_rise)   r_flag <= 1'b0;
        end
    end

    assign bus.pulse_count    = r_count;
    assign bus.period_out     = r_period;
    assign bus.high_width_out = r_width;
    assign bus.period_valid   = r_pv;
    assign bus.width_valid    = r_wv;
    assign bus.timeout_flag   = r_flag;
    assign bus.busy_state     = (r_state != c_IDLE);

`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
    logic [31:0] r_pmin;
    logic [31:0] r_pmax;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pmin <= 32'hFFFF_FFFF;
            r_pmax <= '0;
        end else if (bus.cnt_clear) begin
            r_pmin <= 32'hFFFF_FFFF;
            r_pmax <= '0;
        end else if (w_period_stb) begin
            if (r_elapsed < r_pmin) r_pmin <= r_elapsed;
            if (r_elapsed > r_pmax) r_pmax <= r_elapsed;
        end
    end

    assign bus.period_min = r_pmin;
    assign bus.period_max = r_pmax;
`endif
endmodule
`default_nettype wire

// File: tb/tb_step_pulse_capture.sv
`default_nettype none
//==============================================================================
// Module      : tb_step_pulse_capture
// Description : Directed bench for step_pulse_capture against a pin-level
//               timestamp model. Honours STEP_PULSE_CAPTURE_MINMAX_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_step_pulse_capture;
    localparam int SYNC = 2;
    localparam int NF   = 4;
    localparam int HMAX = 65536;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pv_cnt   = 0;
    int   wv_cnt   = 0;
    bit   chk_en   = 1'b0;

    bit          ph [HMAX];
    bit          dh [HMAX];
    bit          eh [HMAX];
    bit          ch [HMAX];
    bit          ih [HMAX];
    logic [31:0] th [HMAX];

    bit          m_filt  = 1'b0;
    bit          m_track = 1'b0;
    bit          m_high  = 1'b0;
    bit          m_flag  = 1'b0;
    bit          m_pv    = 1'b0;
    bit          m_wv    = 1'b0;
    int          m_ref   = 0;
    logic [31:0] m_cnt   = '0;
    logic [31:0] m_per   = '0;
    logic [31:0] m_wid   = '0;
    logic [31:0] m_min   = 32'hFFFF_FFFF;
    logic [31:0] m_max   = '0;

    step_pulse_capture_if bus();

    step_pulse_capture #(
        .SYNC_STAGES        (SYNC),
        .GLITCH_FILTER_CLKS (NF)
    ) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Outputs after clock edge t, derived from pin history: a level run of NF
    // samples becomes an edge acted on SYNC+2 cycles after the run ends.
    task automatic model_step(input int t);
        bit          en, clr, flip, v, rise, fall, to;
        logic [31:0] tp;
        int          k;
        en   = eh[t-1];
        clr  = ch[t-1];
        tp   = th[t-1];
        m_pv = 1'b0;
        m_wv = 1'b0;
        if (clr) begin
            m_cnt  = '0;
            m_flag = 1'b0;
            m_min  = 32'hFFFF_FFFF;
            m_max  = '0;
        end
        if (!en) begin
            m_track = 1'b0;
            m_filt  = ih[t-1];
        end else begin
            k    = t - SYNC - 2;
            flip = 1'b0;
            v    = 1'b0;
            if (k - NF + 1 >= 0) begin
                v    = ph[k];
                flip = (v != m_filt);
                for (int i = 1; i < NF; i++) if (ph[k-i] != v) flip = 1'b0;
            end
            if (flip) m_filt = v;
            rise = flip && (v != ih[t-1]);
            fall = flip && (v == ih[t-1]);
            to   = m_track && (tp != 32'd0) && (32'(t - m_ref) == tp);
            if (rise && !clr) m_cnt = dh[t-SYNC-1] ? m_cnt + 32'd1 : m_cnt - 32'd1;
            if (rise) m_flag = 1'b0;
            if (to) begin
                m_flag  = 1'b1;
                m_track = 1'b0;
            end else if (rise) begin
                if (m_track) begin
                    m_pv  = 1'b1;
                    m_per = 32'(t - m_ref);
                    if (!clr) begin
                        if (m_per < m_min) m_min = m_per;
                        if (m_per > m_max) m_max = m_per;
                    end
                end
                m_track = 1'b1;
                m_high  = 1'b1;
                m_ref   = t;
            end else if (fall && m_track && m_high) begin
                m_wv   = 1'b1;
                m_wid  = 32'(t - m_ref);
                m_high = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                ph[cyc] = bus.pluse_in;
                dh[cyc] = bus.dir_in;
                eh[cyc] = bus.capture_en;
                ch[cyc] = bus.cnt_clear;
                ih[cyc] = bus.pluse_idle_level;
                th[cyc] = bus.timeout_period;
                if (cyc >= 1) model_step(cyc);
                chk("pulse_count",    bus.pulse_count,    m_cnt);
                chk("period_out",     bus.period_out,     m_per);
                chk("high_width_out", bus.high_width_out, m_wid);
                chk("period_valid",   32'(bus.period_valid), 32'(m_pv));
                chk("width_valid",    32'(bus.width_valid),  32'(m_wv));
                chk("timeout_flag",   32'(bus.timeout_flag), 32'(m_flag));
                chk("busy_state",     32'(bus.busy_state),   32'(m_track));
`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
                chk("period_min", bus.period_min, m_min);
                chk("period_max", bus.period_max, m_max);
`endif
                if (bus.period_valid) pv_cnt++;
                if (bus.width_valid)  wv_cnt++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int per);
        bus.pluse_in = ~bus.pluse_idle_level;
        cycles(hi);
        bus.pluse_in = bus.pluse_idle_level;
        cycles(per - hi);
    endtask

    int pv_save;
    int wv_save;

    initial begin
        bus.pluse_in         = 1'b0;
        bus.dir_in           = 1'b1;
        bus.pluse_idle_level = 1'b0;
        bus.capture_en       = 1'b0;
        bus.cnt_clear        = 1'b0;
        bus.timeout_period   = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_pulse_count", bus.pulse_count, 32'd0);
        chk("rst_period_out",  bus.period_out,  32'd0);
        chk("rst_busy",        32'(bus.busy_state), 32'd0);
        bus.capture_en = 1'b1;
        cycles(20);

        // 1: basic train, first edge latency
        bus.pluse_in = 1'b1;
        cycles(6);
        chk("s1_count_before_latency", bus.pulse_count, 32'd0);
        cycles(1);
        chk("s1_count_at_latency", bus.pulse_count, 32'd1);
        chk("s1_busy_at_latency",  32'(bus.busy_state), 32'd1);
        chk("s1_no_first_period",  32'(pv_cnt), 32'd0);
        cycles(23);
        bus.pluse_in = 1'b0;
        cycles(70);
        repeat (4) pulse(30, 100);
        chk("s1_count",   bus.pulse_count,    32'd5);
        chk("s1_period",  bus.period_out,     32'd100);
        chk("s1_width",   bus.high_width_out, 32'd30);
        chk("s1_pv_cnt",  32'(pv_cnt), 32'd4);
        chk("s1_wv_cnt",  32'(wv_cnt), 32'd5);

        // 2: 3-cycle spikes rejected, 4-cycle pulse accepted
        repeat (2) begin
            bus.pluse_in = 1'b1; cycles(30);
            bus.pluse_in = 1'b0; cycles(30);
            bus.pluse_in = 1'b1; cycles(3);
            bus.pluse_in = 1'b0; cycles(37);
        end
        chk("s2_count_spikes", bus.pulse_count,    32'd7);
        chk("s2_width_spikes", bus.high_width_out, 32'd30);
        pulse(4, 100);
        chk("s2_count_4clk",  bus.pulse_count,    32'd8);
        chk("s2_width_4clk",  bus.high_width_out, 32'd4);
        chk("s2_period_4clk", bus.period_out,     32'd100);

        // 3: down count wraps, then back up
        bus.cnt_clear = 1'b1; cycles(1);
        bus.cnt_clear = 1'b0; cycles(5);
        chk("s3_cleared", bus.pulse_count, 32'd0);
        bus.dir_in = 1'b0; cycles(10);
        repeat (2) pulse(30, 100);
        chk("s3_down_wrap", bus.pulse_count, 32'hFFFF_FFFE);
        bus.dir_in = 1'b1; cycles(10);
        repeat (3) pulse(30, 100);
        chk("s3_up_wrap", bus.pulse_count, 32'h0000_0001);

        // 4: timeout exactly 500 cycles after elapsed is loaded
        bus.timeout_period = 32'd500;
        bus.pluse_in = 1'b1; cycles(30);
        bus.pluse_in = 1'b0; cycles(476);
        chk("s4_flag_before", 32'(bus.timeout_flag), 32'd0);
        chk("s4_busy_before", 32'(bus.busy_state),   32'd1);
        cycles(1);
        chk("s4_flag_at", 32'(bus.timeout_flag), 32'd1);
        chk("s4_busy_at", 32'(bus.busy_state),   32'd0);
        cycles(50);
        pv_save = pv_cnt;
        bus.pluse_in = 1'b1; cycles(7);
        chk("s4_flag_cleared",  32'(bus.timeout_flag), 32'd0);
        chk("s4_busy_again",    32'(bus.busy_state),   32'd1);
        chk("s4_no_period",     32'(pv_cnt), 32'(pv_save));
        cycles(23);
        bus.pluse_in = 1'b0; cycles(70);
        bus.timeout_period = '0;

        // 5: inverted train, clear coincident with an active edge
        bus.capture_en = 1'b0;
        bus.pluse_idle_level = 1'b1;
        bus.pluse_in = 1'b1;
        cycles(20);
        bus.capture_en = 1'b1;
        cycles(20);
        repeat (3) pulse(50, 200);
        chk("s5_period", bus.period_out,     32'd200);
        chk("s5_width",  bus.high_width_out, 32'd50);
        bus.pluse_in = 1'b0; cycles(6);
        bus.cnt_clear = 1'b1; cycles(1);
        bus.cnt_clear = 1'b0;
        chk("s5_clear_on_edge", bus.pulse_count, 32'd0);
        cycles(43);
        bus.pluse_in = 1'b1; cycles(150);
        chk("s5_count_after", bus.pulse_count, 32'd0);

        // 6: capture_en dropped mid active phase
        wv_save = wv_cnt;
        bus.pluse_in = 1'b0; cycles(15);
        bus.capture_en = 1'b0; cycles(5);
        bus.pluse_in = 1'b1; cycles(40);
        chk("s6_no_width", 32'(wv_cnt), 32'(wv_save));
        chk("s6_idle",     32'(bus.busy_state), 32'd0);
        chk("s6_count",    bus.pulse_count, 32'd1);
        bus.capture_en = 1'b1; cycles(20);
        bus.cnt_clear = 1'b1; cycles(1);
        bus.cnt_clear = 1'b0; cycles(2);
        pulse(20, 120);
        pulse(20, 80);
        pulse(20, 150);
        pulse(20, 50);
        chk("s6_last_period", bus.period_out, 32'd150);
        chk("s6_count_mm",    bus.pulse_count, 32'd4);
`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
        chk("s6_period_min", bus.period_min, 32'd80);
        chk("s6_period_max", bus.period_max, 32'd150);
`endif

        // asynchronous reset in the middle of a pulse
        chk_en = 1'b0;
        bus.pluse_in = 1'b0; cycles(10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",  bus.pulse_count,    32'd0);
        chk("arst_period", bus.period_out,     32'd0);
        chk("arst_width",  bus.high_width_out, 32'd0);
        chk("arst_busy",   32'(bus.busy_state), 32'd0);
`ifdef STEP_PULSE_CAPTURE_MINMAX_EN
        chk("arst_min", bus.period_min, 32'hFFFF_FFFF);
`endif
        bus.pluse_in = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        chk("arst_count_after", bus.pulse_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
`default_nettype wire
